// File: rtl/tqvp_vga_copper_pkg.sv
// Shared definitions for the VGA copper: opcodes, command fields, reset colours.
package tqvp_vga_copper_pkg;

  localparam logic [1:0] OP_WAIT_Y = 2'b00;
  localparam logic [1:0] OP_SET_BG = 2'b01;
  localparam logic [1:0] OP_SET_FG = 2'b10;
  localparam logic [1:0] OP_END    = 2'b11;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 14;
  localparam int SYNC_BIT = 13;
  localparam int ARG_HI   = 9;
  localparam int ARG_LO   = 0;

  localparam logic [15:0] CMD_END = 16'hC000;

  // Reset colours shared with the peripheral register file.
  localparam logic [5:0] DEFAULT_BG = 6'b010000;
  localparam logic [5:0] DEFAULT_FG = 6'b001011;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tqvp_vga_copper_mem.sv
// Command store: DEPTH x 16 flops, synchronous write, combinational read.
module tqvp_vga_copper_mem
  import tqvp_vga_copper_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  logic [15:0]     wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [15:0]     rdata
);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] mem_d [DEPTH];

  // Next contents: the addressed entry takes the write data, others hold.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Entries reset to END so an unloaded list halts immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= CMD_END;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tqvp_vga_copper.sv
// Raster-synchronised display-list controller driving live bg/fg colours.
//
// state | meaning
// HALT  | idle; colours hold (enable=1) or track base colours (enable=0)
// RUN   | executing the command list, one command per cycle at most
module tqvp_vga_copper
  import tqvp_vga_copper_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            cmd_we,
  input  logic [PC_W-1:0] cmd_addr,
  input  logic [15:0]     cmd_wdata,
  input  logic [5:0]      base_bg,
  input  logic [5:0]      base_fg,
  input  logic            frame_start,
  input  logic [9:0]      vga_y,
  input  logic            hblank,
  output logic [5:0]      bg_color,
  output logic [5:0]      fg_color,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [5:0]      bg_q, bg_d;
  logic [5:0]      fg_q, fg_d;
  logic            done_q, done_d;

  logic [15:0] cmd;
  logic [1:0]  cmd_op;
  logic        cmd_sync;
  logic [9:0]  cmd_arg;
  logic        advance;
  logic        unused_bits;

  tqvp_vga_copper_mem #(.DEPTH(DEPTH), .PC_W(PC_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cmd_we),
    .waddr (cmd_addr),
    .wdata (cmd_wdata),
    .raddr (pc_q),
    .rdata (cmd)
  );

  assign cmd_op      = cmd[OP_HI:OP_LO];
  assign cmd_sync    = cmd[SYNC_BIT];
  assign cmd_arg     = cmd[ARG_HI:ARG_LO];
  assign unused_bits = ^cmd[12:10];

  // Next-state: restart beats disable beats command execution.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bg_d    = bg_q;
    fg_d    = fg_q;
    done_d  = 1'b0;
    advance = 1'b0;
    if (frame_start && enable) begin
      state_d = ST_RUN;
      pc_d    = '0;
      bg_d    = base_bg;
      fg_d    = base_fg;
    end else if (!enable) begin
      state_d = ST_HALT;
      bg_d    = base_bg;
      fg_d    = base_fg;
    end else if (state_q == ST_RUN) begin
      case (cmd_op)
        OP_WAIT_Y: advance = (vga_y >= cmd_arg);
        OP_SET_BG: begin
          if (!cmd_sync || hblank) begin
            bg_d    = cmd_arg[5:0];
            advance = 1'b1;
          end
        end
        OP_SET_FG: begin
          if (!cmd_sync || hblank) begin
            fg_d    = cmd_arg[5:0];
            advance = 1'b1;
          end
        end
        default: begin
          state_d = ST_HALT;
          done_d  = 1'b1;
        end
      endcase
      // Stepping past the last entry ends the list rather than wrapping.
      if (advance) begin
        if (pc_q == PC_W'(DEPTH - 1)) begin
          state_d = ST_HALT;
          done_d  = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
      pc_q    <= '0;
      bg_q    <= DEFAULT_BG;
      fg_q    <= DEFAULT_FG;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bg_q    <= bg_d;
      fg_q    <= fg_d;
      done_q  <= done_d;
    end
  end

  assign bg_color = bg_q;
  assign fg_color = fg_q;
  assign pc       = pc_q;
  assign running  = (state_q == ST_RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_tqvp_vga_copper.sv
// Bench for tqvp_vga_copper: directed table, corner sequences, random vs model.
module tb_tqvp_vga_copper;

  localparam int DEPTH = 8;
  localparam int PC_W  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            cmd_we = 1'b0;
  logic [PC_W-1:0] cmd_addr = '0;
  logic [15:0]     cmd_wdata = '0;
  logic [5:0]      base_bg = '0;
  logic [5:0]      base_fg = '0;
  logic            frame_start = 1'b0;
  logic [9:0]      vga_y = '0;
  logic            hblank = 1'b0;
  logic [5:0]      bg_color, fg_color;
  logic [PC_W-1:0] pc;
  logic            running, done;

  tqvp_vga_copper #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .base_bg(base_bg),
    .base_fg(base_fg), .frame_start(frame_start), .vga_y(vga_y),
    .hblank(hblank), .bg_color(bg_color), .fg_color(fg_color), .pc(pc),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  int done_seen = 0;

  // Reference model: an interpreter of the display list.
  logic [15:0] m_mem [DEPTH];
  bit          m_run;
  int          m_pc;
  int          m_bg, m_fg;
  bit          m_done;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] mk(int op, int sync, int arg);
    logic [15:0] w;
    w = '0;
    w[15:14] = op[1:0];
    w[13]    = sync[0];
    w[9:0]   = arg[9:0];
    return w;
  endfunction

  task automatic model_step();
    logic [15:0] c;
    int op, arg;
    bit step;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'hC000;
      m_run = 0; m_pc = 0; m_bg = 'h10; m_fg = 'h0B; m_done = 0;
      return;
    end
    c = m_mem[m_pc];
    op = int'(c[15:14]);
    arg = int'(c[9:0]);
    m_done = 0;
    step = 0;
    if (frame_start && enable) begin
      m_run = 1; m_pc = 0; m_bg = base_bg; m_fg = base_fg;
    end else if (!enable) begin
      m_run = 0; m_bg = base_bg; m_fg = base_fg;
    end else if (m_run) begin
      if (op == 0) step = (int'(vga_y) >= arg);
      else if (op == 3) begin m_run = 0; m_done = 1; end
      else if (!c[13] || hblank) begin
        if (op == 1) m_bg = arg % 64; else m_fg = arg % 64;
        step = 1;
      end
      if (step) begin
        if (m_pc == DEPTH - 1) begin m_run = 0; m_done = 1; end
        else m_pc = m_pc + 1;
      end
    end
    if (cmd_we) m_mem[cmd_addr] = cmd_wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_bg", 16'(bg_color), 16'(m_bg));
    chk("model_fg", 16'(fg_color), 16'(m_fg));
    chk("model_pc", 16'(pc), 16'(m_pc));
    chk("model_running", 16'(running), 16'(m_run));
    chk("model_done", 16'(done), 16'(m_done));
    if (done === 1'b1) done_seen++;
  endtask

  task automatic wr(int a, logic [15:0] d);
    cmd_we = 1; cmd_addr = a[PC_W-1:0]; cmd_wdata = d;
    tick();
    cmd_we = 0;
  endtask

  task automatic restart();
    enable = 1; frame_start = 1;
    tick();
    frame_start = 0;
  endtask

  typedef struct {
    logic       en, fs;
    logic [5:0] bbg, bfg;
    logic [5:0] ebg, efg;
    logic [2:0] epc;
    logic       erun, edone;
  } vec_t;

  vec_t vt [6];

  initial begin
    int vy;
    vt[0] = '{1, 1, 6'h05, 6'h2A, 6'h05, 6'h2A, 3'd0, 1, 0};
    vt[1] = '{1, 0, 6'h05, 6'h2A, 6'h05, 6'h2A, 3'd0, 0, 1};
    vt[2] = '{1, 0, 6'h05, 6'h2A, 6'h05, 6'h2A, 3'd0, 0, 0};
    vt[3] = '{1, 0, 6'h10, 6'h2A, 6'h05, 6'h2A, 3'd0, 0, 0};
    vt[4] = '{0, 0, 6'h10, 6'h01, 6'h10, 6'h01, 3'd0, 0, 0};
    vt[5] = '{0, 0, 6'h03, 6'h04, 6'h03, 6'h04, 3'd0, 0, 0};

    // Reset
    tick(); tick();
    rst_n = 1;
    #1;
    chk("reset_bg", 16'(bg_color), 16'h10);
    chk("reset_fg", 16'(fg_color), 16'h0B);
    chk("reset_pc", 16'(pc), 16'h0);
    chk("reset_running", 16'(running), 16'h0);
    chk("reset_done", 16'(done), 16'h0);

    // Default END list and halt/disable colour behaviour
    for (int i = 0; i < 6; i++) begin
      enable = vt[i].en; frame_start = vt[i].fs;
      base_bg = vt[i].bbg; base_fg = vt[i].bfg;
      tick();
      chk($sformatf("vec%0d_bg", i), 16'(bg_color), 16'(vt[i].ebg));
      chk($sformatf("vec%0d_fg", i), 16'(fg_color), 16'(vt[i].efg));
      chk($sformatf("vec%0d_pc", i), 16'(pc), 16'(vt[i].epc));
      chk($sformatf("vec%0d_run", i), 16'(running), 16'(vt[i].erun));
      chk($sformatf("vec%0d_done", i), 16'(done), 16'(vt[i].edone));
    end
    frame_start = 0;

    // WAIT_Y 100 then SET_BG 3F
    enable = 0; base_bg = 6'h05; base_fg = 6'h2A;
    wr(0, mk(0, 0, 100));
    wr(1, mk(1, 0, 'h3F));
    wr(2, 16'hC000);
    vga_y = 0;
    restart();
    done_seen = 0;
    for (int y = 0; y <= 120; y++) begin
      vga_y = y[9:0];
      tick();
      if (y == 99) chk("wait_stall_pc", 16'(pc), 16'd0);
      if (y == 100) begin
        chk("wait_pass_pc", 16'(pc), 16'd1);
        chk("wait_bg_still_base", 16'(bg_color), 16'h05);
      end
      if (y == 101) chk("setbg_visible", 16'(bg_color), 16'h3F);
    end
    chk("wait_list_done_once", 16'(done_seen), 16'd1);

    // Sync SET_FG stalls until hblank
    enable = 0;
    wr(0, mk(2, 1, 'h11));
    wr(1, 16'hC000);
    hblank = 0;
    restart();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sync_stall_pc", 16'(pc), 16'd0);
      chk("sync_stall_fg", 16'(fg_color), 16'h2A);
    end
    hblank = 1;
    tick();
    chk("sync_fg_set", 16'(fg_color), 16'h11);
    hblank = 0;
    tick();

    // All entries SET_BG: pc stops at last entry
    enable = 0;
    for (int i = 0; i < DEPTH; i++) wr(i, mk(1, 0, 'h20 + i));
    restart();
    done_seen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("fill_bg", 16'(bg_color), 16'('h20 + i));
      chk("fill_pc", 16'(pc), 16'((i < DEPTH - 1) ? i + 1 : DEPTH - 1));
    end
    chk("fill_halt", 16'(running), 16'd0);
    chk("fill_done", 16'(done), 16'd1);
    tick(); tick();
    chk("fill_pc_hold", 16'(pc), 16'd7);
    chk("fill_done_once", 16'(done_seen), 16'd1);

    // Restart during WAIT_Y 500, then disable mid-run
    enable = 0;
    wr(0, mk(0, 0, 500));
    vga_y = 10;
    restart();
    done_seen = 0;
    repeat (5) tick();
    chk("wait500_pc", 16'(pc), 16'd0);
    chk("wait500_run", 16'(running), 16'd1);
    base_bg = 6'h0C; base_fg = 6'h33;
    restart();
    chk("abort_pc", 16'(pc), 16'd0);
    chk("abort_bg", 16'(bg_color), 16'h0C);
    chk("abort_fg", 16'(fg_color), 16'h33);
    repeat (3) tick();
    chk("abort_no_done", 16'(done_seen), 16'd0);
    enable = 0; base_bg = 6'h15; base_fg = 6'h2B;
    tick();
    chk("disable_run", 16'(running), 16'd0);
    chk("disable_bg", 16'(bg_color), 16'h15);
    base_bg = 6'h01;
    tick();
    chk("disable_track_bg", 16'(bg_color), 16'h01);
    chk("disable_track_fg", 16'(fg_color), 16'h2B);

    // Write to the executing entry: old command wins this frame
    wr(0, mk(1, 0, 'h07));
    wr(1, 16'hC000);
    base_bg = 6'h00;
    restart();
    cmd_we = 1; cmd_addr = 0; cmd_wdata = mk(1, 0, 'h19);
    tick();
    cmd_we = 0;
    chk("wr_old_cmd", 16'(bg_color), 16'h07);
    tick();
    restart();
    tick();
    chk("wr_new_cmd", 16'(bg_color), 16'h19);

    // Randomised traffic against the model
    vy = 0;
    for (int n = 0; n < 3000; n++) begin
      int op;
      enable = ($urandom_range(0, 39) != 0);
      frame_start = ($urandom_range(0, 149) == 0);
      if (frame_start) vy = 0; else vy = (vy + 1) % 525;
      vga_y = vy[9:0];
      hblank = ($urandom_range(0, 3) == 0);
      base_bg = 6'($urandom); base_fg = 6'($urandom);
      cmd_we = ($urandom_range(0, 11) == 0);
      cmd_addr = PC_W'($urandom);
      op = $urandom_range(0, 3);
      cmd_wdata = mk(op, $urandom_range(0, 1),
                     (op == 0) ? $urandom_range(0, 300) : $urandom_range(0, 1023));
      cmd_wdata[12:10] = 3'($urandom);
      tick();
    end
    cmd_we = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tqvp_vga_copper.md
Name: tqvp_vga_copper

Overview:
- Raster-synchronised display-list controller that sequences colour-register updates for the VGA peripheral during a frame.
- The CPU loads a small command list. Each frame the block executes the list and updates the live background/foreground colours at chosen scanlines, optionally only inside horizontal blank.
- Sits between the peripheral register file (base colours, command writes) and the pixel colour mux.

Parameters:
- DEPTH, 8, number of command entries (power of two, 2..16).
- PC_W, 3, pc width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  copper enable; low forces HALT and base colours.
- cmd_we  in  1  command write strobe.
- cmd_addr  in  PC_W  command entry index.
- cmd_wdata  in  16  command word.
- base_bg  in  6  CPU background colour, reloaded each frame.
- base_fg  in  6  CPU foreground colour, reloaded each frame.
- frame_start  in  1  one-cycle pulse at the first cycle of line 0.
- vga_y  in  10  current scanline.
- hblank  in  1  horizontal blank active.
- bg_color  out  6  live background colour to the pixel mux.
- fg_color  out  6  live foreground colour to the pixel mux.
- pc  out  PC_W  current command index.
- running  out  1  high in RUN state.
- done  out  1  one-cycle pulse when the list finishes.

Behaviour:
- Command word format:
  - op = [15:14]; sync = [13]; arg = [9:0].
  - op 00 WAIT_Y: wait until vga_y >= arg.
  - op 01 SET_BG: bg <= arg[5:0].
  - op 10 SET_FG: fg <= arg[5:0].
  - op 11 END.
- Command store: DEPTH x 16 flops.
  - Reset value of every entry is 16'hC000 (END).
  - Read is combinational: cmd = mem[pc].
  - A write is visible from the next cycle; the executing entry uses its old value in the write cycle.
- Reset values:
  - state HALT, pc 0, running 0, done 0.
  - bg_color 6'b010000, fg_color 6'b001011.
- State machine has two states, HALT and RUN.
- Restart (priority 1):
  - Condition: frame_start and enable.
  - Effect: state RUN, pc <= 0, bg_color <= base_bg, fg_color <= base_fg.
  - No command executes that cycle.
- Disable (priority 2):
  - Condition: !enable.
  - Effect: state HALT; bg_color and fg_color track base_bg and base_fg every cycle (1-cycle register latency).
- HALT with enable: colours hold their last value; no restart until the next frame_start.
- RUN executes at most one command per cycle:
  - WAIT_Y: if vga_y >= arg, pc++ this cycle; else stall (pc held).
  - SET_BG / SET_FG with sync=0: colour register updated this cycle, pc++.
  - SET_BG / SET_FG with sync=1: stall until hblank=1, then update and pc++ in the same cycle.
  - END: state HALT, done pulses the next cycle, pc holds.
- pc wrap: pc++ from DEPTH-1 is treated as END (HALT + done). pc never wraps to 0 inside a frame.
- Colour latency: a colour change is visible on bg_color / fg_color one cycle after the executing cycle (registered).
- A frame_start during RUN aborts the list and restarts it; no done pulse is issued.
- running = (state == RUN).
- A WAIT_Y target above the last visible line stalls until the next frame_start; this is legal and not an error.

Decomposition:
- Shared package: opcode constants (OP_WAIT_Y, OP_SET_BG, OP_SET_FG, OP_END), the command bit-field positions, and the reset colour constants shared with the peripheral (DEFAULT_BG 6'b010000, DEFAULT_FG 6'b001011).
- One natural sub-module: tqvp_vga_copper_mem, the DEPTH x 16 command store with synchronous write port and combinational read port.
- Decode and FSM stay in the top module.

Test Plan:
- Reset, then enable=1 with base_bg=6'h05 and base_fg=6'h2A, pulse frame_start -> next cycle bg_color=6'h05, fg_color=6'h2A, pc=0, running=1; the default END list halts one cycle later and done pulses once.
- List {WAIT_Y 100, SET_BG 6'h3F, END}, vga_y ramps 0..120 -> bg_color becomes 6'h3F exactly one cycle after the cycle vga_y reaches 100; done pulses once.
- SET_FG 6'h11 with sync=1 and hblank low for 20 cycles -> pc held at that entry and fg_color unchanged; the cycle after hblank rises fg_color=6'h11.
- All 8 entries SET_BG (no END) -> pc runs to 7, then HALT, done pulses once, pc stays 7.
- frame_start while stalled on WAIT_Y 500 -> pc=0, colours reloaded from base, no done pulse; enable dropped mid-run -> running=0 and colours follow base_bg/base_fg within 1 cycle.
- cmd_we writes mem[pc] during the cycle it executes -> old command takes effect; the new value is used on the next frame.
